// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: exc_vec_i bit map, ExcCodes,
// vector offsets, FSM encodings and the request/response structs.
package exc_ctrl_pkg;

  localparam int EXC_VEC_W   = 13;
  localparam int EXC_IF_ADEL = 0;
  localparam int EXC_IF_TLBR = 1;
  localparam int EXC_IF_TLBI = 2;
  localparam int EXC_CPU     = 3;
  localparam int EXC_RI      = 4;
  localparam int EXC_SYS     = 5;
  localparam int EXC_BP      = 6;
  localparam int EXC_OV      = 7;
  localparam int EXC_D_ADEL  = 8;
  localparam int EXC_D_ADES  = 9;
  // Data TLB causes are packed: 2-bit kind at [11:10] plus the load/store bit at [12].
  localparam int EXC_D_TLB   = 10;
  localparam int EXC_D_ST    = 12;

  localparam logic [1:0] DTLB_NONE   = 2'd0;
  localparam logic [1:0] DTLB_REFILL = 2'd1;
  localparam logic [1:0] DTLB_INV    = 2'd2;
  localparam logic [1:0] DTLB_MOD    = 2'd3;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_MOD  = 5'd1;
  localparam logic [4:0] CODE_TLBL = 5'd2;
  localparam logic [4:0] CODE_TLBS = 5'd3;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_CPU  = 5'd11;
  localparam logic [4:0] CODE_OV   = 5'd12;

  localparam logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200;
  localparam logic [11:0] OFF_REFILL   = 12'h000;
  localparam logic [11:0] OFF_INT      = 12'h200;
  localparam logic [11:0] OFF_GEN      = 12'h180;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    logic       badv_we;
    logic       asid_we;
    logic       is_refill;
    logic       is_eret;
    logic       is_int;
  } exc_sel_t;

  typedef struct packed {
    exc_sel_t    sel;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] badv;
    logic [31:0] vec;
  } exc_req_t;

  typedef struct packed {
    logic        en_exp;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] bad_vaddr;
    logic        badv_we;
    logic        asid_we;
    logic        clean_exl;
    logic        hold;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
  } exc_out_t;

  function automatic exc_sel_t mk_sel(input logic [4:0] code, input logic badv,
                                      input logic asid, input logic refill);
    exc_sel_t s;
    s           = '0;
    s.valid     = 1'b1;
    s.code      = code;
    s.badv_we   = badv;
    s.asid_we   = asid;
    s.is_refill = refill;
    return s;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: interrupt, exception flags and ERET -> one selected cause.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic                 int_req_i,
  input  logic [EXC_VEC_W-1:0] flags_i,
  input  logic                 eret_i,
  output exc_sel_t             sel_o
);

  logic [1:0] dtlb;
  assign dtlb = flags_i[EXC_D_TLB +: 2];

  always_comb begin
    sel_o = '0;
    if (int_req_i) begin
      sel_o        = mk_sel(CODE_INT, 1'b0, 1'b0, 1'b0);
      sel_o.is_int = 1'b1;
    end
    else if (flags_i[EXC_IF_ADEL])                        sel_o = mk_sel(CODE_ADEL, 1'b1, 1'b0, 1'b0);
    else if (flags_i[EXC_IF_TLBR] || flags_i[EXC_IF_TLBI]) sel_o = mk_sel(CODE_TLBL, 1'b1, 1'b1, flags_i[EXC_IF_TLBR]);
    else if (flags_i[EXC_CPU])                             sel_o = mk_sel(CODE_CPU, 1'b0, 1'b0, 1'b0);
    else if (flags_i[EXC_RI])                              sel_o = mk_sel(CODE_RI, 1'b0, 1'b0, 1'b0);
    else if (flags_i[EXC_SYS])                             sel_o = mk_sel(CODE_SYS, 1'b0, 1'b0, 1'b0);
    else if (flags_i[EXC_BP])                              sel_o = mk_sel(CODE_BP, 1'b0, 1'b0, 1'b0);
    else if (flags_i[EXC_OV])                              sel_o = mk_sel(CODE_OV, 1'b0, 1'b0, 1'b0);
    else if (flags_i[EXC_D_ADEL])                          sel_o = mk_sel(CODE_ADEL, 1'b1, 1'b0, 1'b0);
    else if (flags_i[EXC_D_ADES])                          sel_o = mk_sel(CODE_ADES, 1'b1, 1'b0, 1'b0);
    else if (dtlb == DTLB_REFILL || dtlb == DTLB_INV)
      sel_o = mk_sel(flags_i[EXC_D_ST] ? CODE_TLBS : CODE_TLBL, 1'b1, 1'b1, dtlb == DTLB_REFILL);
    else if (dtlb == DTLB_MOD)                             sel_o = mk_sel(CODE_MOD, 1'b1, 1'b1, 1'b0);
    else if (eret_i) begin
      sel_o.valid   = 1'b1;
      sel_o.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer in front of CP0: prioritise, wait for uncancellable
// memory traffic, commit, redirect and flush. Define INT_SYNC_EN to synchronise hw_int_i.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int EXC_W        = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid_i,
  input  logic [31:0]      pc_i,
  input  logic             in_ds_i,
  input  logic [EXC_W-1:0] exc_vec_i,
  // ERET request bit appended to the exception flags by the MEM stage
  input  logic             eret_i,
  input  logic [31:0]      bad_vaddr_i,
  input  logic             mem_busy_i,
  input  logic [5:0]       hw_int_i,
  input  logic [1:0]       sw_int_i,
  input  logic [7:0]       int_mask_i,
  input  logic             allow_int_i,
  input  logic             in_exl_i,
  input  logic             bev_i,
  input  logic             iv_i,
  input  logic [19:0]      ebase_i,
  input  logic [31:0]      epc_i,
  output logic             en_exp_o,
  output logic [4:0]       exp_code_o,
  output logic [31:0]      exp_epc_o,
  output logic             exp_bd_o,
  output logic [31:0]      exp_bad_vaddr_o,
  output logic             exp_badv_we_o,
  output logic             exp_asid_we_o,
  output logic             clean_exl_o,
  output logic             hold_o,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [5:0] hw_int_s;
`ifdef INT_SYNC_EN
  logic [5:0] hw_meta_q, hw_sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hw_meta_q <= '0;
      hw_sync_q <= '0;
    end else begin
      hw_meta_q <= hw_int_i;
      hw_sync_q <= hw_meta_q;
    end
  end
  assign hw_int_s = hw_sync_q;
`else
  assign hw_int_s = hw_int_i;
`endif

  logic                 int_req, eret_req;
  logic [EXC_VEC_W-1:0] flags;
  exc_sel_t             sel;

  assign int_req  = instr_valid_i & allow_int_i & (|({hw_int_s, sw_int_i} & int_mask_i));
  assign eret_req = instr_valid_i & eret_i;
  assign flags    = instr_valid_i ? exc_vec_i[EXC_VEC_W-1:0] : '0;

  exc_prio_enc u_prio (
    .int_req_i (int_req),
    .flags_i   (flags),
    .eret_i    (eret_req),
    .sel_o     (sel)
  );

  exc_req_t    now_req, src, pend_q, pend_d;
  logic [31:0] base;
  logic [11:0] offset;

  always_comb begin
    base = bev_i ? VEC_BEV_BASE : {ebase_i, 12'h000};
    if (sel.is_refill && !in_exl_i) offset = OFF_REFILL;
    else if (sel.is_int && iv_i)    offset = OFF_INT;
    else                            offset = OFF_GEN;
    now_req.sel  = sel;
    now_req.epc  = in_ds_i ? pc_i - 32'd4 : pc_i;
    now_req.bd   = in_ds_i;
    now_req.badv = bad_vaddr_i;
    now_req.vec  = base + {20'h0, offset};
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (sel.valid) begin
        pend_d = now_req;
        if (mem_busy_i) state_d = S_WAIT;
        else begin
          state_d = S_COMMIT;
          commit  = 1'b1;
        end
      end
      S_WAIT: if (!mem_busy_i) begin
        state_d = S_COMMIT;
        commit  = 1'b1;
      end
      S_COMMIT: if (FLUSH_CYCLES > 1) begin
        state_d = S_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 2);
      end else state_d = S_IDLE;
      default: if (cnt_q == '0) state_d = S_IDLE;
               else cnt_d = cnt_q - 1'b1;
    endcase
  end

  // Waiting requests commit the values captured on entry, not the live MEM stage.
  assign src = (state_q == S_WAIT) ? pend_q : now_req;

  exc_out_t out_q, out_d;

  always_comb begin
    out_d = '0;
    if (commit) begin
      out_d.redirect = 1'b1;
      if (src.sel.is_eret) begin
        out_d.clean_exl   = 1'b1;
        out_d.redirect_pc = epc_i;
      end else begin
        out_d.en_exp      = 1'b1;
        out_d.code        = src.sel.code;
        out_d.epc         = src.epc;
        out_d.bd          = src.bd;
        out_d.badv_we     = src.sel.badv_we;
        out_d.asid_we     = src.sel.asid_we;
        out_d.bad_vaddr   = src.sel.badv_we ? src.badv : 32'h0;
        out_d.redirect_pc = src.vec;
      end
    end
    out_d.flush = (state_d == S_COMMIT) || (state_d == S_FLUSH);
    out_d.hold  = (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign en_exp_o        = out_q.en_exp;
  assign exp_code_o      = out_q.code;
  assign exp_epc_o       = out_q.epc;
  assign exp_bd_o        = out_q.bd;
  assign exp_bad_vaddr_o = out_q.bad_vaddr;
  assign exp_badv_we_o   = out_q.badv_we;
  assign exp_asid_we_o   = out_q.asid_we;
  assign clean_exl_o     = out_q.clean_exl;
  assign hold_o          = out_q.hold;
  assign flush_o         = out_q.flush;
  assign redirect_o      = out_q.redirect;
  assign redirect_pc_o   = out_q.redirect_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: hand-computed expectations checked with immediate assertions.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk, rst_n;
  logic        instr_valid, in_ds, eret, mem_busy, allow_int, in_exl, bev, iv;
  logic [31:0] pc, bad_vaddr, epc;
  logic [12:0] exc_vec;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic [7:0]  int_mask;
  logic [19:0] ebase;
  logic        en_exp, bd, badv_we, asid_we, clean_exl, hold, flush, redirect;
  logic [4:0]  code;
  logic [31:0] exp_epc, exp_badv, rpc;

  int n_chk  = 0;
  int n_pass = 0;

  exc_ctrl #(.FLUSH_CYCLES(2), .EXC_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .pc_i(pc), .in_ds_i(in_ds),
    .exc_vec_i(exc_vec), .eret_i(eret), .bad_vaddr_i(bad_vaddr), .mem_busy_i(mem_busy),
    .hw_int_i(hw_int), .sw_int_i(sw_int), .int_mask_i(int_mask), .allow_int_i(allow_int),
    .in_exl_i(in_exl), .bev_i(bev), .iv_i(iv), .ebase_i(ebase), .epc_i(epc),
    .en_exp_o(en_exp), .exp_code_o(code), .exp_epc_o(exp_epc), .exp_bd_o(bd),
    .exp_bad_vaddr_o(exp_badv), .exp_badv_we_o(badv_we), .exp_asid_we_o(asid_we),
    .clean_exl_o(clean_exl), .hold_o(hold), .flush_o(flush), .redirect_o(redirect),
    .redirect_pc_o(rpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Full output vector: strobe, clean_exl, code, epc, bd, badv, badv_we, asid_we, redirect, pc, flush, hold
  task automatic chk_all(input string t, input logic e, input logic c, input logic [4:0] cd,
                         input logic [31:0] ep, input logic b, input logic [31:0] bv,
                         input logic bw, input logic aw, input logic rd, input logic [31:0] rp,
                         input logic fl, input logic hd);
    chk({t, ".en_exp"},    32'(en_exp),    32'(e));
    chk({t, ".clean_exl"}, 32'(clean_exl), 32'(c));
    chk({t, ".code"},      32'(code),      32'(cd));
    chk({t, ".epc"},       exp_epc,        ep);
    chk({t, ".bd"},        32'(bd),        32'(b));
    chk({t, ".badv"},      exp_badv,       bv);
    chk({t, ".badv_we"},   32'(badv_we),   32'(bw));
    chk({t, ".asid_we"},   32'(asid_we),   32'(aw));
    chk({t, ".redirect"},  32'(redirect),  32'(rd));
    chk({t, ".rpc"},       rpc,            rp);
    chk({t, ".flush"},     32'(flush),     32'(fl));
    chk({t, ".hold"},      32'(hold),      32'(hd));
  endtask

  task automatic idle_in();
    instr_valid = 0; pc = 0; in_ds = 0; exc_vec = '0; eret = 0; bad_vaddr = 0;
    mem_busy = 0; hw_int = 0; sw_int = 0; int_mask = 0; allow_int = 0;
    in_exl = 0; bev = 0; iv = 0;
  endtask

  // Two-cycle flush tail after a commit, then quiet IDLE.
  task automatic flush_tail(input string t);
    step();
    chk_all({t, ".flush1"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk_all({t, ".idle"},   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; ebase = 20'h80000; epc = 0;
    idle_in();
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;

    // Syscall, BEV=0 -> general vector
    instr_valid = 1; pc = 32'h8000_1000; exc_vec[EXC_SYS] = 1;
    step();
    idle_in();
    chk_all("sys", 1, 0, 8, 32'h8000_1000, 0, 0, 0, 0, 1, 32'h8000_0180, 1, 0);
    flush_tail("sys");

    // Data TLB refill on a load in a delay slot, BEV=1
    instr_valid = 1; pc = 32'h0040_0010; in_ds = 1; bev = 1; bad_vaddr = 32'h1234_5000;
    exc_vec[EXC_D_TLB +: 2] = DTLB_REFILL;
    step();
    idle_in();
    chk_all("dtlbr", 1, 0, 2, 32'h0040_000C, 1, 32'h1234_5000, 1, 1, 1, 32'hBFC0_0200, 1, 0);
    flush_tail("dtlbr");

    // Instruction TLB refill with EXL set falls back to the general vector
    instr_valid = 1; pc = 32'h8000_5000; in_exl = 1; bad_vaddr = 32'h8000_5000;
    exc_vec[EXC_IF_TLBR] = 1;
    step();
    idle_in();
    chk_all("itlbr_exl", 1, 0, 2, 32'h8000_5000, 0, 32'h8000_5000, 1, 1, 1, 32'h8000_0180, 1, 0);
    flush_tail("itlbr_exl");

    // Interrupt beats RI; IV=1 selects the 0x200 offset
    hw_int = 6'b000001; int_mask = 8'b0000_0100; allow_int = 1; iv = 1;
`ifdef INT_SYNC_EN
    step();
    chk("int_sync.wait1", 32'(en_exp), 0);
    step();
    chk("int_sync.wait2", 32'(en_exp), 0);
`endif
    instr_valid = 1; pc = 32'h8000_3000; exc_vec[EXC_RI] = 1;
    step();
    idle_in();
    chk_all("int", 1, 0, 0, 32'h8000_3000, 0, 0, 0, 0, 1, 32'h8000_0200, 1, 0);
    flush_tail("int");

    // Exception on an ERET instruction wins over the ERET
    instr_valid = 1; pc = 32'h8000_6000; eret = 1; exc_vec[EXC_SYS] = 1;
    step();
    idle_in();
    chk_all("eret_sup", 1, 0, 8, 32'h8000_6000, 0, 0, 0, 0, 1, 32'h8000_0180, 1, 0);
    flush_tail("eret_sup");

    // AdES held off by an uncancellable access; changed inputs during WAIT are ignored
    instr_valid = 1; pc = 32'h8000_4000; bad_vaddr = 32'h0000_0003; mem_busy = 1;
    exc_vec[EXC_D_ADES] = 1;
    step();
    chk_all("wait0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    pc = 32'hDEAD_0000; bad_vaddr = 32'hFFFF_FFF0; in_ds = 1; exc_vec = '0; exc_vec[EXC_SYS] = 1;
    step();
    chk("wait1.hold", 32'(hold), 1);
    step();
    chk("wait2.hold", 32'(hold), 1);
    idle_in();
    step();
    chk_all("ades", 1, 0, 5, 32'h8000_4000, 0, 32'h0000_0003, 1, 0, 1, 32'h8000_0180, 1, 0);
    flush_tail("ades");

    // ERET: clears EXL and jumps to EPC
    instr_valid = 1; eret = 1; epc = 32'h8000_2000;
    step();
    idle_in();
    chk_all("eret", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_2000, 1, 0);
    flush_tail("eret");

    // Ov raised during COMMIT/FLUSH belongs to a killed instruction
    instr_valid = 1; pc = 32'h8000_7000; exc_vec[EXC_SYS] = 1;
    step();
    chk("ovflush.commit", 32'(en_exp), 1);
    exc_vec = '0; exc_vec[EXC_OV] = 1;
    step();
    chk_all("ovflush.flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    idle_in();
    chk_all("ovflush.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_all("ovflush.quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while in WAIT discards the pending cause
    instr_valid = 1; pc = 32'h8000_8000; bad_vaddr = 32'h11; mem_busy = 1;
    exc_vec[EXC_D_ADEL] = 1;
    step();
    chk("rstwait.hold", 32'(hold), 1);
    rst_n = 0;
    idle_in();
    step();
    chk_all("rstwait.rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    step();
    chk_all("rstwait.rel1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_all("rstwait.rel2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
